// File: rtl/apb_master_ctrl_if.sv
// Requester-side and APB-side signal bundle for apb_master_ctrl.
// The master modport is the controller's view; slave is the environment's view.
interface apb_master_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master: one transfer at a time from a valid/ready requester onto three decoded slaves.
// Defining APB_TIMEOUT_EN adds an ACCESS-phase abort after TIMEOUT_CYCLES wait cycles.
module apb_master_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic               pclk_i,
    input logic               presetn_i,
    apb_master_ctrl_if.master bus_io
);
    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDecerr} state_e;

    state_e      state_q, state_d;
    logic [2:0]  pselx_q, pselx_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d     = state_q;
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.req_valid) begin
                    pwrite_d = bus_io.req_write;
                    paddr_d  = bus_io.req_addr;
                    pwdata_d = bus_io.req_wdata;
                    unique case (bus_io.req_addr[13:12])
                        2'd0: begin pselx_d = 3'b001; state_d = StSetup; end
                        2'd1: begin pselx_d = 3'b010; state_d = StSetup; end
                        2'd2: begin pselx_d = 3'b100; state_d = StSetup; end
                        // Unmapped window: no select, answer with an error.
                        default: state_d = StDecerr;
                    endcase
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            StAccess: begin
                if (bus_io.pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? 32'h0 : bus_io.prdata;
                    rsp_err_d   = bus_io.pslverr;
                    pselx_d     = 3'b000;
                    penable_d   = 1'b0;
                    state_d     = StIdle;
                end
`ifdef APB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_d == CntW'(TIMEOUT_CYCLES)) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                        pselx_d     = 3'b000;
                        penable_d   = 1'b0;
                        state_d     = StIdle;
                    end
                end
`endif
            end
            StDecerr: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'h0;
                rsp_err_d   = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q     <= StIdle;
            pselx_q     <= 3'b000;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus_io.req_ready = (state_q == StIdle);
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.rsp_err   = rsp_err_q;
    assign bus_io.pselx     = pselx_q;
    assign bus_io.penable   = penable_q;
    assign bus_io.pwrite    = pwrite_q;
    assign bus_io.paddr     = paddr_q;
    assign bus_io.pwdata    = pwdata_q;
endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB master controller sequencing single read/write transfers from a simple valid/ready requester port onto the APB bus toward up to three slaves. Owns the IDLE/SETUP/ACCESS protocol, one-hot slave select decode, wait-state handling via `pready` and error reporting via `pslverr`. Sits between the system-side command source and the APB pass-through interface, driving its `pwrite`/`penable`/`pselx`/`paddr`/`pwdata` inputs and consuming `prdata`.

## Interface
- `TIMEOUT_CYCLES`, default 16: max ACCESS cycles before abort; used only with `APB_TIMEOUT_EN`.
- `pclk` input 1: single clock; all logic on rising edge.
- `presetn` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: requester has a transfer.
- `req_ready` output 1: controller accepts the transfer this cycle.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input 32: transfer address.
- `req_wdata` input 32: write data.
- `rsp_valid` output 1: one-cycle pulse, transfer finished.
- `rsp_rdata` output 32: read data, valid with `rsp_valid`.
- `rsp_err` output 1: error flag, valid with `rsp_valid`.
- `pselx` output 3: one-hot slave select.
- `penable` output 1: APB enable.
- `pwrite` output 1: APB direction.
- `paddr` output 32: APB address.
- `pwdata` output 32: APB write data.
- `prdata` input 32: APB read data.
- `pready` input 1: slave ready.
- `pslverr` input 1: slave error.

## Operation
- States: IDLE, SETUP, ACCESS, DECERR.
- IDLE: `req_ready`=1. On `req_valid`: latch `req_write`/`req_addr`/`req_wdata` into `pwrite`/`paddr`/`pwdata`; decode `req_addr[13:12]`: 0→`pselx`=3'b001, 1→3'b010, 2→3'b100, then go to SETUP; 3→unmapped, `pselx` stays 0, go to DECERR.
- SETUP: `pselx` asserted, `penable`=0; unconditionally go to ACCESS.
- ACCESS: `penable`=1, `pselx`/`paddr`/`pwrite`/`pwdata` held stable. With `pready`=0, stay. With `pready`=1, complete: capture `prdata` into `rsp_rdata` if read (write: `rsp_rdata`=0), `rsp_err`=`pslverr`, pulse `rsp_valid`, clear `pselx`/`penable`, go to IDLE.
- DECERR: no bus activity; pulse `rsp_valid` with `rsp_err`=1, `rsp_rdata`=0; go to IDLE.
- `req_ready`=0 in all states but IDLE; no back-to-back pipelining.
- `pslverr` is sampled only when `pready`=1 in ACCESS; ignored otherwise.
- `paddr`/`pwdata`/`pwrite` hold last values in IDLE (not cleared).

## Timing
- All outputs registered. Reset values: `req_ready`=1 (state IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `pselx`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0.
- Request accepted at edge E0 (`req_valid`&&`req_ready`). Cycle after E0: SETUP. Cycle after E1: ACCESS. Zero-wait slave: `rsp_valid` high in cycle after E2. This gives 3 cycles from acceptance to response, plus N extra for N wait cycles.
- `req_ready` returns high in the same cycle `rsp_valid` pulses. A new request accepted at that edge goes to SETUP next cycle.
- DECERR: `rsp_valid` high in the second cycle after acceptance.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). The transfer is dropped and no response is issued.

## Configuration
- `APB_TIMEOUT_EN` defined: a cycle counter clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0. When the count reaches `TIMEOUT_CYCLES`, the transfer aborts: `pselx`/`penable` drop, `rsp_valid` pulses with `rsp_err`=1 and `rsp_rdata`=0, and the state goes to IDLE. `pready` arriving in the abort cycle wins, and the transfer completes normally.
- Not defined: no counter; ACCESS waits indefinitely for `pready`.

## Test plan
- Reset release, then write addr 0x0000_0004, data 0xDEAD_BEEF, `pready` tied 1 → `pselx`=001 in SETUP and ACCESS; `penable` high for exactly 1 cycle; `rsp_valid` with `rsp_err`=0, 3 cycles after acceptance.
- Read addr 0x0000_2010, slave holds `pready`=0 for 4 cycles then returns `prdata`=0x0000_0019 → `pselx`=100, ACCESS lasts 5 cycles, `rsp_rdata`=0x19, address and controls stable throughout.
- Read addr 0x0000_3000 → no `pselx`/`penable` activity; `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0 two cycles after acceptance.
- Write to 0x0000_1000 with `pslverr`=1 alongside `pready` → `pselx`=010, `rsp_err`=1; `pslverr` pulses while `pready`=0 are ignored.
- `req_valid` held high for two back-to-back requests → second accepted in the `rsp_valid` cycle of the first; `req_ready` low throughout SETUP/ACCESS.
- `presetn` low during ACCESS → outputs at reset values immediately, no `rsp_valid`. With `APB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `pready` stuck at 0 → abort after 16 ACCESS cycles with `rsp_err`=1.
